// File: rtl/can_loader_pkg.sv
// rtl/can_loader_pkg.sv - command/response codes, loader state encoding and byte-count helper
package can_loader_pkg;

  localparam logic [7:0] CMD_LOADP = 8'h01;
  localparam logic [7:0] CMD_LOADD = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h03;
  localparam logic [7:0] CMD_DUMP  = 8'h04;

  localparam logic [7:0] RSP_OK      = 8'hA5;
  localparam logic [7:0] RSP_BADCMD  = 8'hEE;
  localparam logic [7:0] RSP_TIMEOUT = 8'hEF;
  localparam logic [7:0] RSP_CSUM    = 8'hEC;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_PAYLOAD,
    ST_CSUM,
    ST_WRITE,
    ST_RUN,
    ST_WAIT,
    ST_READ,
    ST_SEND,
    ST_RESP
  } state_e;

  function automatic int bytes_for(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/can_loader_shiftreg.sv
// rtl/can_loader_shiftreg.sv - byte-in/byte-out word shift register with byte counter
module can_loader_shiftreg #(
  parameter int NBYTES = 64,
  parameter int CW     = $clog2(NBYTES + 1)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [NBYTES*8-1:0]   word_i,
  input  logic                  shift_in_i,
  input  logic [7:0]            byte_i,
  input  logic                  shift_out_i,
  output logic [NBYTES*8-1:0]   word_o,
  output logic [7:0]            byte_o,
  output logic [CW-1:0]         cnt_o
);
  localparam int W = NBYTES * 8;

  logic [W-1:0]  word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Bytes enter at the top, so after N shifts the LSB-first word sits in the top N lanes.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      word_d = word_i;
      cnt_d  = '0;
    end else if (shift_in_i) begin
      word_d = {byte_i, word_q[W-1:8]};
      cnt_d  = cnt_q + 1'b1;
    end else if (shift_out_i) begin
      word_d = {8'h00, word_q[W-1:8]};
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o = word_q;
  assign byte_o = word_q[7:0];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/can_core_loader.sv
// rtl/can_core_loader.sv - host byte-stream loader/runner for CanCore memories;
// CAN_LOADER_CHECKSUM_EN adds an XOR checksum byte and a response to every LOAD.
module can_core_loader
  import can_loader_pkg::*;
#(
  parameter int PROG_ADDR_W  = 7,
  parameter int PROG_DATA_W  = 20,
  parameter int DATA_ADDR_W  = 4,
  parameter int DATA_DATA_W  = 512,
  parameter int READ_LATENCY = 1,
  parameter int RUN_TIMEOUT  = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [7:0]             io_in_bits,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [7:0]             io_out_bits,
  output logic                   io_busy,
  output logic                   io_take,
  input  logic                   io_halted,
  output logic                   io_programMemory_write_en,
  output logic [PROG_ADDR_W-1:0] io_programMemory_write_addr,
  output logic [PROG_DATA_W-1:0] io_programMemory_write_data,
  output logic                   io_dataMemory_write_en,
  output logic [DATA_ADDR_W-1:0] io_dataMemory_write_addr,
  output logic [DATA_DATA_W-1:0] io_dataMemory_write_data,
  output logic [DATA_ADDR_W-1:0] io_dataMemory_read_addr,
  input  logic [DATA_DATA_W-1:0] io_dataMemory_read_data
);
  localparam int NB_P   = bytes_for(PROG_DATA_W);
  localparam int NB_D   = bytes_for(DATA_DATA_W);
  localparam int NB_MAX = (NB_P > NB_D) ? NB_P : NB_D;
  localparam int SR_W   = NB_MAX * 8;
  localparam int CW     = $clog2(NB_MAX + 1);
  localparam int AW     = (PROG_ADDR_W > DATA_ADDR_W) ? PROG_ADDR_W : DATA_ADDR_W;
  localparam int LW     = $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] LAST_P       = CW'(NB_P - 1);
  localparam logic [CW-1:0] LAST_D       = CW'(NB_D - 1);
  localparam logic [LW-1:0] RD_LAST      = LW'(READ_LATENCY);
  localparam logic [31:0]   TIMEOUT_LAST = 32'(RUN_TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic                   is_data_q, is_data_d;
  logic                   is_dump_q, is_dump_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [DATA_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]             rsp_q, rsp_d;
  logic [LW-1:0]          rd_cnt_q, rd_cnt_d;
  logic [31:0]            wait_cnt_q, wait_cnt_d;
`ifdef CAN_LOADER_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  logic            in_fire;
  logic            sr_clear, sr_load, sr_shift_in, sr_shift_out;
  logic [SR_W-1:0] sr_word, load_word;
  logic [7:0]      sr_byte;
  logic [CW-1:0]   sr_cnt;

  always_comb begin
    load_word = '0;
    load_word[DATA_DATA_W-1:0] = io_dataMemory_read_data;
  end

  can_loader_shiftreg #(.NBYTES(NB_MAX), .CW(CW)) u_shiftreg (
    .clock_i     (clock),
    .reset_i     (reset),
    .clear_i     (sr_clear),
    .load_i      (sr_load),
    .word_i      (load_word),
    .shift_in_i  (sr_shift_in),
    .byte_i      (io_in_bits),
    .shift_out_i (sr_shift_out),
    .word_o      (sr_word),
    .byte_o      (sr_byte),
    .cnt_o       (sr_cnt)
  );

  assign io_in_ready = (state_q == ST_IDLE) || (state_q == ST_ADDR) ||
                       (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
  assign in_fire     = io_in_valid && io_in_ready;

  always_comb begin
    state_d      = state_q;
    is_data_d    = is_data_q;
    is_dump_d    = is_dump_q;
    addr_d       = addr_q;
    rd_addr_d    = rd_addr_q;
    rsp_d        = rsp_q;
    rd_cnt_d     = rd_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    sr_clear     = 1'b0;
    sr_load      = 1'b0;
    sr_shift_in  = 1'b0;
    sr_shift_out = 1'b0;
`ifdef CAN_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      ST_IDLE: if (in_fire) begin
        is_data_d = (io_in_bits == CMD_LOADD);
        is_dump_d = (io_in_bits == CMD_DUMP);
        case (io_in_bits)
          CMD_LOADP, CMD_LOADD, CMD_DUMP: state_d = ST_ADDR;
          CMD_RUN:                        state_d = ST_RUN;
          default: begin
            rsp_d   = RSP_BADCMD;
            state_d = ST_RESP;
          end
        endcase
      end
      ST_ADDR: if (in_fire) begin
        addr_d   = io_in_bits[AW-1:0];
        sr_clear = 1'b1;
`ifdef CAN_LOADER_CHECKSUM_EN
        csum_d   = io_in_bits;
`endif
        if (is_dump_q) begin
          rd_addr_d = io_in_bits[DATA_ADDR_W-1:0];
          rd_cnt_d  = '0;
          state_d   = ST_READ;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: if (in_fire) begin
        sr_shift_in = 1'b1;
`ifdef CAN_LOADER_CHECKSUM_EN
        csum_d = csum_q ^ io_in_bits;
        if (sr_cnt == (is_data_q ? LAST_D : LAST_P)) state_d = ST_CSUM;
`else
        if (sr_cnt == (is_data_q ? LAST_D : LAST_P)) state_d = ST_WRITE;
`endif
      end
`ifdef CAN_LOADER_CHECKSUM_EN
      ST_CSUM: if (in_fire) begin
        if (io_in_bits == csum_q) begin
          state_d = ST_WRITE;
        end else begin
          rsp_d   = RSP_CSUM;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: begin
        rsp_d   = RSP_OK;
        state_d = ST_RESP;
      end
`else
      ST_WRITE: state_d = ST_IDLE;
`endif
      ST_RUN: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      // The first two WAIT cycles ignore io_halted, which may still show the previous run.
      ST_WAIT: begin
        if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 32'd1;
        if ((wait_cnt_q >= 32'd2) && io_halted) begin
          rsp_d   = RSP_OK;
          state_d = ST_RESP;
        end else if ((RUN_TIMEOUT > 0) && (wait_cnt_q == TIMEOUT_LAST)) begin
          rsp_d   = RSP_TIMEOUT;
          state_d = ST_RESP;
        end
      end
      ST_READ: begin
        if (rd_cnt_q == RD_LAST) begin
          sr_load = 1'b1;
          state_d = ST_SEND;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      ST_SEND: if (io_out_ready) begin
        sr_shift_out = 1'b1;
        if (sr_cnt == LAST_D) state_d = ST_IDLE;
      end
      ST_RESP: if (io_out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      is_data_q  <= 1'b0;
      is_dump_q  <= 1'b0;
      addr_q     <= '0;
      rd_addr_q  <= '0;
      rsp_q      <= '0;
      rd_cnt_q   <= '0;
      wait_cnt_q <= '0;
`ifdef CAN_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      is_data_q  <= is_data_d;
      is_dump_q  <= is_dump_d;
      addr_q     <= addr_d;
      rd_addr_q  <= rd_addr_d;
      rsp_q      <= rsp_d;
      rd_cnt_q   <= rd_cnt_d;
      wait_cnt_q <= wait_cnt_d;
`ifdef CAN_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign io_busy      = (state_q != ST_IDLE);
  assign io_take      = (state_q == ST_RUN);
  assign io_out_valid = (state_q == ST_SEND) || (state_q == ST_RESP);
  assign io_out_bits  = (state_q == ST_SEND) ? sr_byte : rsp_q;

  assign io_programMemory_write_en   = (state_q == ST_WRITE) && !is_data_q;
  assign io_programMemory_write_addr = addr_q[PROG_ADDR_W-1:0];
  assign io_programMemory_write_data = sr_word[(NB_MAX-NB_P)*8 +: PROG_DATA_W];
  assign io_dataMemory_write_en      = (state_q == ST_WRITE) && is_data_q;
  assign io_dataMemory_write_addr    = addr_q[DATA_ADDR_W-1:0];
  assign io_dataMemory_write_data    = sr_word[(NB_MAX-NB_D)*8 +: DATA_DATA_W];
  assign io_dataMemory_read_addr     = rd_addr_q;

endmodule

// File: tb/tb_can_core_loader.sv
// tb/tb_can_core_loader.sv - randomized self-checking bench for can_core_loader with memory/core models
module tb_can_core_loader;
  localparam int PAW = 7;
  localparam int PDW = 20;
  localparam int DAW = 4;
  localparam int DDW = 512;
  localparam int RL  = 2;
  localparam int RTO = 40;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [7:0]     in_bits = 8'h00;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [7:0]     out_bits;
  logic           busy, take;
  logic           halted = 1'b0;
  logic           pwe, dwe;
  logic [PAW-1:0] pwa;
  logic [PDW-1:0] pwd;
  logic [DAW-1:0] dwa, rd_addr;
  logic [DDW-1:0] dwd, rd_data;

  can_core_loader #(
    .PROG_ADDR_W(PAW), .PROG_DATA_W(PDW), .DATA_ADDR_W(DAW), .DATA_DATA_W(DDW),
    .READ_LATENCY(RL), .RUN_TIMEOUT(RTO)
  ) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(in_ready), .io_in_bits(in_bits),
    .io_out_valid(out_valid), .io_out_ready(out_ready), .io_out_bits(out_bits),
    .io_busy(busy), .io_take(take), .io_halted(halted),
    .io_programMemory_write_en(pwe), .io_programMemory_write_addr(pwa),
    .io_programMemory_write_data(pwd),
    .io_dataMemory_write_en(dwe), .io_dataMemory_write_addr(dwa),
    .io_dataMemory_write_data(dwd),
    .io_dataMemory_read_addr(rd_addr), .io_dataMemory_read_data(rd_data)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Data memory attached to the DUT, with a READ_LATENCY-deep read pipeline.
  logic [DDW-1:0] dmem [16];
  logic [DDW-1:0] pipe [RL];
  assign rd_data = pipe[RL-1];
  always @(posedge clock) begin
    pipe[0] <= dmem[rd_addr];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    if (dwe) dmem[dwa] = dwd;
  end

  // Core model: raises halted halt_delay cycles after take; 0 means never halts.
  int halt_delay = 0;
  int hcnt = 0;
  always @(negedge clock) begin
    if (reset) begin
      halted = 1'b0; hcnt = 0;
    end else if (take) begin
      halted = 1'b0; hcnt = halt_delay;
    end else if (hcnt > 0) begin
      hcnt--;
      if (hcnt == 0) halted = 1'b1;
    end
  end

  int rdy_mode = 0;
  always @(posedge clock) begin
    #2;
    if (rdy_mode == 0) out_ready = 1'b1;
    else out_ready = ~out_ready;
  end

  logic [7:0]     rx_q [$];
  logic [PAW-1:0] pw_addr_q [$];
  logic [PDW-1:0] pw_data_q [$];
  logic [DAW-1:0] dw_addr_q [$];
  logic [DDW-1:0] dw_data_q [$];
  int             take_cycles = 0;
  logic           prev_hold = 1'b0;
  logic [7:0]     prev_bits = 8'h00;

  always @(negedge clock) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) check("out_hold", {out_valid, out_bits}, {1'b1, prev_bits});
      if (out_valid && out_ready) rx_q.push_back(out_bits);
      prev_hold = out_valid && !out_ready;
      prev_bits = out_bits;
      if (pwe) begin pw_addr_q.push_back(pwa); pw_data_q.push_back(pwd); end
      if (dwe) begin dw_addr_q.push_back(dwa); dw_data_q.push_back(dwd); end
      if (pwe || dwe) check("we_exclusive", pwe & dwe, 1'b0);
      if (take) take_cycles++;
    end
  end

  logic [DDW-1:0] ref_dmem [16];

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_obs();
    rx_q.delete(); pw_addr_q.delete(); pw_data_q.delete();
    dw_addr_q.delete(); dw_data_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1; in_bits = b;
    @(negedge clock);
    while (!in_ready && n < 200) begin @(negedge clock); n++; end
    check("in_ready_wait", (n < 200), 1'b1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin @(negedge clock); k++; end
    check(tag, (rx_q.size() >= n), 1'b1);
  endtask

  function automatic logic [7:0] pop_rx();
    if (rx_q.size() > 0) return rx_q.pop_front();
    return 8'hxx;
  endfunction

  task automatic do_load(input bit is_data, input logic [7:0] abyte, input logic [7:0] pl[],
                         input bit corrupt);
    logic [511:0] w = '0;
    bit expect_write;
`ifdef CAN_LOADER_CHECKSUM_EN
    logic [7:0] cs = abyte;
    foreach (pl[i]) cs ^= pl[i];
`endif
    foreach (pl[i]) w[i*8 +: 8] = pl[i];
    if (!is_data) for (int b = PDW; b < 512; b++) w[b] = 1'b0;
    clear_obs();
    send_byte(is_data ? 8'h02 : 8'h01);
    send_byte(abyte);
    foreach (pl[i]) send_byte(pl[i]);
`ifdef CAN_LOADER_CHECKSUM_EN
    send_byte(corrupt ? ~cs : cs);
    expect_write = !corrupt;
    wait_rx(1, 50, "load_rsp_wait");
    check("load_rsp", pop_rx(), corrupt ? 8'hEC : 8'hA5);
`else
    expect_write = !corrupt;
    cyc(6);
    check("load_no_rsp", rx_q.size(), 0);
`endif
    cyc(2);
    if (is_data) begin
      check("loadd_writes", dw_addr_q.size(), expect_write ? 1 : 0);
      check("loadd_no_prog", pw_addr_q.size(), 0);
      if (expect_write && dw_addr_q.size() > 0) begin
        check("loadd_addr", dw_addr_q[0], abyte[DAW-1:0]);
        check("loadd_data", dw_data_q[0], w);
        ref_dmem[abyte[DAW-1:0]] = w[DDW-1:0];
      end
    end else begin
      check("loadp_writes", pw_addr_q.size(), expect_write ? 1 : 0);
      check("loadp_no_data", dw_addr_q.size(), 0);
      if (expect_write && pw_addr_q.size() > 0) begin
        check("loadp_addr", pw_addr_q[0], abyte[PAW-1:0]);
        check("loadp_data", pw_data_q[0], w);
      end
    end
    check("load_idle", busy, 1'b0);
  endtask

  task automatic do_dump(input logic [7:0] abyte, input int mode);
    logic [DDW-1:0] w = ref_dmem[abyte[DAW-1:0]];
    clear_obs();
    rdy_mode = mode;
    send_byte(8'h04);
    send_byte(abyte);
    wait_rx(64, 1000, "dump_wait");
    for (int i = 0; i < 64; i++) check("dump_byte", pop_rx(), w[i*8 +: 8]);
    cyc(4);
    check("dump_extra", rx_q.size(), 0);
    check("dump_idle", busy, 1'b0);
    check("dump_rd_addr", rd_addr, abyte[DAW-1:0]);
    rdy_mode = 0;
  endtask

  task automatic do_run(input int delay, input logic [7:0] exp);
    clear_obs();
    halt_delay = delay;
    take_cycles = 0;
    send_byte(8'h03);
    wait_rx(1, 300, "run_wait");
    check("run_rsp", pop_rx(), exp);
    cyc(2);
    check("run_take_width", take_cycles, 1);
    check("run_busy_after", busy, 1'b0);
  endtask

  logic [7:0] pl [];
  logic [7:0] pp [];
  logic [7:0] a;

  initial begin
    for (int i = 0; i < 16; i++) begin dmem[i] = '0; ref_dmem[i] = '0; end
    cyc(3);
    check("reset_ctrl", {busy, take, out_valid, out_bits, pwe, dwe, rd_addr, pwa, dwa}, '0);
    check("reset_wdata", {pwd, dwd}, '0);
    check("reset_in_ready", in_ready, 1'b1);
    reset = 1'b0;
    cyc(2);

    pp = new[3];
    pp[0] = 8'hDE; pp[1] = 8'hBC; pp[2] = 8'h0A;
    do_load(1'b0, 8'h05, pp, 1'b0);
    if (pw_data_q.size() > 0) check("loadp_abcde", pw_data_q[0], 20'hABCDE);

    pl = new[64];
    foreach (pl[i]) pl[i] = 8'(i);
    do_load(1'b1, 8'h13, pl, 1'b0);
    do_dump(8'h03, 1);

    clear_obs();
    send_byte(8'h7F);
    wait_rx(1, 50, "badcmd_wait");
    check("badcmd_rsp", pop_rx(), 8'hEE);
    cyc(2);
    check("badcmd_idle", busy, 1'b0);

    do_run(10, 8'hA5);
    do_run(0, 8'hEF);
    do_run(5, 8'hA5);

    for (int it = 0; it < 4; it++) begin
      a = 8'($urandom);
      foreach (pl[i]) pl[i] = 8'($urandom);
      do_load(1'b1, a, pl, 1'b0);
      foreach (pp[i]) pp[i] = 8'($urandom);
      do_load(1'b0, 8'($urandom), pp, 1'b0);
      do_dump(a, int'($urandom_range(0, 1)));
    end

    clear_obs();
    send_byte(8'h02);
    send_byte(8'h13);
    for (int i = 0; i < 10; i++) send_byte(8'hC0 + 8'(i));
    reset = 1'b1;
    cyc(2);
    check("midrst_idle", {busy, in_ready}, 2'b01);
    reset = 1'b0;
    cyc(4);
    check("midrst_no_write", dw_addr_q.size() + pw_addr_q.size(), 0);
    check("midrst_no_rsp", rx_q.size(), 0);
    pp[0] = 8'h11; pp[1] = 8'h22; pp[2] = 8'h03;
    do_load(1'b0, 8'h7E, pp, 1'b0);
    do_dump(8'h03, 0);

`ifdef CAN_LOADER_CHECKSUM_EN
    foreach (pl[i]) pl[i] = 8'($urandom);
    do_load(1'b1, 8'h07, pl, 1'b0);
    foreach (pl[i]) pl[i] = 8'($urandom);
    do_load(1'b1, 8'h07, pl, 1'b1);
    do_dump(8'h07, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
